// File: rtl/risc_pkg.sv
// Shared encodings for the VeriRISC controller: opcodes, FSM states and
// the ALU-operation classifier used by the output decoder.
package risc_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_e;

    // Instructions that read an operand from memory into the accumulator path
    function automatic logic is_aluop(input opcode_e op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/risc_controller.sv
// VeriRISC sequencing controller: 8-state Moore FSM that decodes state and
// the current opcode into datapath strobes. Outputs are unregistered decode.
module risc_controller
    import risc_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  opcode_e opcode,
    input  logic    zero,
    output logic    mem_rd,
    output logic    load_ir,
    output logic    halt,
    output logic    inc_pc,
    output logic    load_ac,
    output logic    load_pc,
    output logic    mem_wr,
    output logic    sel
);

    state_e state;
    state_e state_next;
    // All eight state codes are used, so "halted" is a separate flag that
    // latches HLT on the first OP_ADDR edge; afterwards the opcode input
    // no longer influences the FSM or the outputs.
    logic   halted;
    logic   halt_now;

    assign halt_now = halted || (opcode == HLT);

    // State register and halt latch, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= INST_ADDR;
            halted <= 1'b0;
        end else begin
            state <= state_next;
            if (state == OP_ADDR && opcode == HLT)
                halted <= 1'b1;
        end
    end

    // Next-state: linear sequence, parked in OP_ADDR once halted
    always_comb begin
        state_next = INST_ADDR;
        case (state)
            INST_ADDR:  state_next = INST_FETCH;
            INST_FETCH: state_next = INST_LOAD;
            INST_LOAD:  state_next = IDLE;
            IDLE:       state_next = OP_ADDR;
            OP_ADDR:    state_next = halt_now ? OP_ADDR : OP_FETCH;
            OP_FETCH:   state_next = ALU_OP;
            ALU_OP:     state_next = STORE;
            STORE:      state_next = INST_ADDR;
            default:    state_next = INST_ADDR;
        endcase
    end

    // Output decode from state and opcode; unlisted strobes stay low
    always_comb begin
        sel     = 1'b0;
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        case (state)
            INST_ADDR: begin
                sel = 1'b1;
            end
            INST_FETCH: begin
                sel    = 1'b1;
                mem_rd = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel     = 1'b1;
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                halt   = halt_now;
                inc_pc = !halt_now;
            end
            OP_FETCH: begin
                mem_rd = is_aluop(opcode);
            end
            ALU_OP: begin
                mem_rd  = is_aluop(opcode);
                load_ac = is_aluop(opcode);
                inc_pc  = (opcode == SKZ) && zero;
                load_pc = (opcode == JMP);
            end
            STORE: begin
                mem_rd  = is_aluop(opcode);
                load_ac = is_aluop(opcode);
                inc_pc  = (opcode == JMP);
                load_pc = (opcode == JMP);
                mem_wr  = (opcode == STO);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_risc_controller.sv
// Directed bench for risc_controller: walks full instruction cycles per
// opcode against hand-written per-state output vectors.
module tb_risc_controller;
    import risc_pkg::*;

    logic    clk;
    logic    rst_n;
    opcode_e opcode;
    logic    zero;
    logic    mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, sel;

    int unsigned checks;
    int unsigned failures;

    // Output vector order: {sel, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}
    logic [7:0] outs;
    assign outs = {sel, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};

    risc_controller dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .opcode  (opcode),
        .zero    (zero),
        .mem_rd  (mem_rd),
        .load_ir (load_ir),
        .halt    (halt),
        .inc_pc  (inc_pc),
        .load_ac (load_ac),
        .load_pc (load_pc),
        .mem_wr  (mem_wr),
        .sel     (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Walk one full instruction starting at an INST_ADDR negedge.
    // Ends at the next INST_ADDR negedge.
    task automatic run_instr(input string name, input logic [7:0] exp [8]);
        for (int unsigned i = 0; i < 8; i++) begin
            check($sformatf("%s_s%0d", name, i), outs, exp[i]);
            @(negedge clk);
        end
    endtask

    logic [7:0] v_add  [8] = '{8'h80, 8'hC0, 8'hE0, 8'hE0, 8'h08, 8'h40, 8'h44, 8'h44};
    logic [7:0] v_sto  [8] = '{8'h80, 8'hC0, 8'hE0, 8'hE0, 8'h08, 8'h00, 8'h00, 8'h01};
    logic [7:0] v_skz1 [8] = '{8'h80, 8'hC0, 8'hE0, 8'hE0, 8'h08, 8'h00, 8'h08, 8'h00};
    logic [7:0] v_skz0 [8] = '{8'h80, 8'hC0, 8'hE0, 8'hE0, 8'h08, 8'h00, 8'h00, 8'h00};
    logic [7:0] v_jmp  [8] = '{8'h80, 8'hC0, 8'hE0, 8'hE0, 8'h08, 8'h00, 8'h02, 8'h0A};

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        opcode   = ADD;
        zero     = 1'b0;

        // Reset held for three cycles: sel only
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_c%0d", i), outs, 8'h80);
        end
        rst_n = 1'b1;

        run_instr("add", v_add);
        opcode = STO;
        run_instr("sto", v_sto);
        opcode = SKZ;
        zero   = 1'b1;
        run_instr("skz_z1", v_skz1);
        zero   = 1'b0;
        run_instr("skz_z0", v_skz0);
        opcode = JMP;
        run_instr("jmp", v_jmp);

        // Halt: park in OP_ADDR, opcode changes ignored
        opcode = HLT;
        for (int unsigned i = 0; i < 4; i++) begin
            check($sformatf("hlt_s%0d", i), outs, v_add[i]);
            @(negedge clk);
        end
        for (int unsigned i = 0; i < 22; i++) begin
            if (i == 5)  opcode = ADD;
            if (i == 12) opcode = JMP;
            check($sformatf("hlt_hold%0d", i), outs, 8'h10);
            @(negedge clk);
        end
        opcode = ADD;
        rst_n  = 1'b0;
        #1;
        check("hlt_reset", outs, 8'h80);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr("after_hlt", v_add);

        // Asynchronous reset mid-ALU_OP
        for (int unsigned i = 0; i < 6; i++) @(negedge clk);
        check("pre_async_aluop", outs, 8'h44);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs, 8'h80);
        @(negedge clk);
        check("async_hold", outs, 8'h80);
        rst_n = 1'b1;
        run_instr("after_async", v_add);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/risc_controller.md
# risc_controller

- Moore-style sequencing controller for the VeriRISC datapath.
- Steps through an 8-state, 8-cycle instruction cycle and decodes state plus current opcode into datapath strobes.
- Drives the `sel` input of the address `scale_mux`: 1 selects the program counter (`in_a`), 0 selects the IR operand address (`in_b`).
- Also drives memory, IR, accumulator and PC load/increment controls.

## Interface
Parameters:
- none; opcode and state encodings come from the shared package.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  3  instruction opcode from the IR (`opcode_e`); stable from INST_LOAD to the end of STORE.
- `zero`  in  1  accumulator-is-zero flag.
- `mem_rd`  out  1  memory read enable.
- `load_ir`  out  1  instruction register load.
- `halt`  out  1  processor halted.
- `inc_pc`  out  1  program counter increment.
- `load_ac`  out  1  accumulator load.
- `load_pc`  out  1  program counter load (jump).
- `mem_wr`  out  1  memory write enable.
- `sel`  out  1  address mux select: 1 = PC, 0 = operand.

## Operation
Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = opcode in {ADD, AND, XOR, LDA}.

States advance one per cycle, in order, wrapping STORE -> INST_ADDR: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE.

Outputs are decoded from state and opcode; any signal not listed is 0:
- INST_ADDR: sel=1.
- INST_FETCH: sel=1, mem_rd=1.
- INST_LOAD: sel=1, mem_rd=1, load_ir=1.
- IDLE: sel=1, mem_rd=1, load_ir=1.
- OP_ADDR: halt=(opcode==HLT), inc_pc=(opcode!=HLT).
- OP_FETCH: mem_rd=ALUOP.
- ALU_OP: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==SKZ && zero), load_pc=(opcode==JMP).
- STORE: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==JMP), load_pc=(opcode==JMP), mem_wr=(opcode==STO).

Halt behaviour:
- HLT in OP_ADDR: the FSM holds in OP_ADDR with halt=1 and inc_pc=0 until reset.
- While halted, opcode changes are ignored.

Invariants:
- mem_rd and mem_wr are never 1 in the same cycle.
- No output is undefined for any state/opcode combination, including an illegal state (default -> INST_ADDR next, all outputs 0).

## Timing
- Reset (asynchronous assert, at any point including mid-instruction): state = INST_ADDR immediately. Outputs become sel=1, all others 0, within the same cycle, not waiting for the clock.
- Reset release: first rising edge with rst_n=1 moves to INST_FETCH.
- Non-halting instruction: exactly 8 cycles, INST_ADDR to STORE.
- load_ir is asserted for 2 cycles (INST_LOAD, IDLE).
- Opcode is sampled combinationally. A change during OP_ADDR..STORE takes effect in the same cycle; the datapath must hold the IR.
- SKZ with zero=1: inc_pc pulses in OP_ADDR and in ALU_OP, so PC advances by 2 over the instruction.
- JMP: load_pc and inc_pc are both high in STORE. load_pc has priority in the PC; the controller still drives both.
- Outputs are glitch-tolerant decode only; they are not registered.

## Structure
- Package `risc_pkg`:
  - `opcode_e` (3-bit enum, values above).
  - `state_e` (3-bit enum, INST_ADDR=0 .. STORE=7).
  - function `is_aluop(opcode_e)`.
- Single module `risc_controller`; no sub-module.
- One `always_ff` for the state register with async reset.
- One `always_comb` for next state and one `always_comb` for outputs.

## Test plan
- Reset asserted for 3 cycles, then released, opcode=ADD, zero=0 -> outputs sel=1, others 0 during reset. Then 8-cycle sequence with load_ac=1 in ALU_OP and STORE, and inc_pc=1 only in OP_ADDR.
- opcode=STO -> mem_wr=1 only in STORE; mem_rd=0 in OP_FETCH, ALU_OP and STORE.
- opcode=SKZ with zero=1, then zero=0 -> inc_pc high in 2 cycles (OP_ADDR, ALU_OP), then in 1 cycle (OP_ADDR).
- opcode=JMP -> load_pc=1 in ALU_OP and STORE; inc_pc=1 in OP_ADDR and STORE.
- opcode=HLT -> halt=1 from OP_ADDR onward, held for 20+ cycles with inc_pc=0. rst_n pulse then restarts at INST_ADDR with halt=0.
- rst_n asserted asynchronously in ALU_OP, mid-cycle -> sel=1 and all others 0 before the next clock edge; sequence restarts at INST_ADDR.
